// File: rtl/tap_pkg.sv
// tap_pkg: TAP state encoding, instruction opcodes and IR capture pattern
package tap_pkg;
  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPDATE_DR,
    SEL_IR, CAP_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPDATE_IR
  } tap_state_e;
  localparam int OP_EXTEST = 0;
  localparam int OP_IDCODE = 1;
  localparam int OP_SAMPLE = 2;
  localparam int OP_PRELOAD = 3;
  localparam logic [31:0] OP_BYPASS = '1;
  localparam int IR_CAPTURE = 1;
endpackage

// File: rtl/tap_fsm.sv
// tap_fsm: 16-state TAP state register and TMS-driven next-state logic
module tap_fsm
  import tap_pkg::*;
(
  input  logic       tck_i,
  input  logic       rst_i,
  input  logic       tms_i,
  output tap_state_e state_o,
  output tap_state_e next_o
);
  always_ff @(posedge tck_i) state_o <= rst_i ? TLR : next_o;
  always_comb begin
    next_o = TLR;
    case (state_o)
      TLR:                  next_o = tms_i ? TLR : RTI;
      RTI:                  next_o = tms_i ? SEL_DR : RTI;
      SEL_DR:               next_o = tms_i ? SEL_IR : CAP_DR;
      SEL_IR:               next_o = tms_i ? TLR : CAP_IR;
      CAP_DR, SHIFT_DR:     next_o = tms_i ? EXIT1_DR : SHIFT_DR;
      EXIT1_DR:             next_o = tms_i ? UPDATE_DR : PAUSE_DR;
      PAUSE_DR:             next_o = tms_i ? EXIT2_DR : PAUSE_DR;
      EXIT2_DR:             next_o = tms_i ? UPDATE_DR : SHIFT_DR;
      CAP_IR, SHIFT_IR:     next_o = tms_i ? EXIT1_IR : SHIFT_IR;
      EXIT1_IR:             next_o = tms_i ? UPDATE_IR : PAUSE_IR;
      PAUSE_IR:             next_o = tms_i ? EXIT2_IR : PAUSE_IR;
      EXIT2_IR:             next_o = tms_i ? UPDATE_IR : SHIFT_IR;
      UPDATE_DR, UPDATE_IR: next_o = tms_i ? SEL_DR : RTI;
      default:              next_o = TLR;
    endcase
  end
endmodule

// File: rtl/tap_controller.sv
// tap_controller: JTAG TAP with IR, IDCODE/bypass registers, BSR strobes and TDO mux
module tap_controller
  import tap_pkg::*;
#(
  parameter int          IR_LEN     = 4,
  parameter logic [31:0] IDCODE_VAL = 32'h1000_0001
) (
  input  logic       tck_i,
  input  logic       rst_i,
  input  logic       tms_i,
  input  logic       tdi_i,
  input  logic       bsr_so_i,
  output logic       tdo_o,
  output logic       tdo_en_o,
  output logic       bsr_si_o,
  output logic       clock_dr_en_o,
  output logic       shift_dr_o,
  output logic       update_dr_o,
  output logic       sample_o,
  output logic       preload_o,
  output logic       mode_o,
  output logic [3:0] tap_state_o
);
  localparam logic [IR_LEN-1:0] EXTEST = IR_LEN'(OP_EXTEST);
  localparam logic [IR_LEN-1:0] IDCODE = IR_LEN'(OP_IDCODE);
  localparam logic [IR_LEN-1:0] SAMPLE = IR_LEN'(OP_SAMPLE);
  localparam logic [IR_LEN-1:0] PRELOAD = IR_LEN'(OP_PRELOAD);
  tap_state_e state, nxt_state;
  logic [IR_LEN-1:0] ir_q, ir_shift;
  logic [31:0] idcode_shift;
  logic bypass, sel_bsr, sel_idcode;
  tap_fsm u_fsm (
    .tck_i  (tck_i),
    .rst_i  (rst_i),
    .tms_i  (tms_i),
    .state_o(state),
    .next_o (nxt_state)
  );
  assign sel_bsr = ir_q == EXTEST || ir_q == SAMPLE || ir_q == PRELOAD;
  assign sel_idcode = ir_q == IDCODE;
  always_ff @(posedge tck_i) begin
    if (rst_i) begin
      ir_q <= IDCODE;
      ir_shift <= '0;
      idcode_shift <= '0;
      bypass <= 1'b0;
    end else begin
      if (state == CAP_IR) ir_shift <= IR_LEN'(IR_CAPTURE);
      if (state == SHIFT_IR) ir_shift <= {tdi_i, ir_shift[IR_LEN-1:1]};
      if (nxt_state == TLR) ir_q <= IDCODE;
      else if (state == UPDATE_IR) ir_q <= ir_shift;
      if (state == CAP_DR) begin
        idcode_shift <= IDCODE_VAL;
        bypass <= 1'b0;
      end
      if (state == SHIFT_DR && sel_idcode) idcode_shift <= {tdi_i, idcode_shift[31:1]};
      if (state == SHIFT_DR && !sel_bsr && !sel_idcode) bypass <= tdi_i;
    end
  end
  // Any opcode not decoded as BSR or IDCODE falls through to the bypass bit
  assign tdo_o = state == SHIFT_IR ? ir_shift[0] :
                 state != SHIFT_DR ? 1'b0 :
                 sel_bsr ? bsr_so_i : sel_idcode ? idcode_shift[0] : bypass;
  assign tdo_en_o = state == SHIFT_IR || state == SHIFT_DR;
  assign bsr_si_o = tdi_i;
  assign sample_o = ir_q == SAMPLE || ir_q == EXTEST;
  assign preload_o = ir_q == PRELOAD || ir_q == EXTEST;
  assign mode_o = ir_q == EXTEST;
  assign clock_dr_en_o = sel_bsr && (state == CAP_DR || state == SHIFT_DR);
  assign shift_dr_o = state == SHIFT_DR;
  assign update_dr_o = sel_bsr && state == UPDATE_DR;
  assign tap_state_o = state;
endmodule

// File: tb/tb_tap_controller.sv
// tb_tap_controller: vector table, directed sequences and random TMS/TDI against a queue-based model
module tb_tap_controller;
  import tap_pkg::*;
  localparam logic [31:0] IDV = 32'h1000_0001;
  logic tck = 0, rst = 1, tms = 1, tdi = 0, bsr_so = 0;
  logic tdo, tdo_en, bsr_si, clock_dr_en, shift_dr, update_dr, sample, preload, mode;
  logic [3:0] tap_state;
  int errors = 0, checks = 0;
  tap_controller #(.IR_LEN(4), .IDCODE_VAL(IDV)) dut (
    .tck_i(tck), .rst_i(rst), .tms_i(tms), .tdi_i(tdi), .bsr_so_i(bsr_so),
    .tdo_o(tdo), .tdo_en_o(tdo_en), .bsr_si_o(bsr_si), .clock_dr_en_o(clock_dr_en),
    .shift_dr_o(shift_dr), .update_dr_o(update_dr), .sample_o(sample),
    .preload_o(preload), .mode_o(mode), .tap_state_o(tap_state)
  );
  always #5 tck = ~tck;
  tap_state_e nxt [16][2];
  tap_state_e m_st = TLR;
  int m_ir = 1;
  bit irq[$];
  bit drq[$];
  typedef struct {
    logic r, t, d;
    tap_state_e st;
    logic tdo, en, mode;
  } vec_t;
  vec_t tbl [12];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic arc(input tap_state_e s, input tap_state_e on0, input tap_state_e on1);
    nxt[int'(s)][0] = on0;
    nxt[int'(s)][1] = on1;
  endtask
  function automatic bit is_bsr(input int ir);
    return ir == 0 || ir == 2 || ir == 3;
  endfunction
  task automatic model_edge(input logic r, input logic t, input logic d);
    tap_state_e s = m_st;
    if (r) begin
      m_st = TLR;
      m_ir = 1;
      irq = {};
      for (int i = 0; i < 4; i++) irq.push_back(1'b0);
      drq = {};
      return;
    end
    if (s == CAP_IR) begin
      irq = {};
      for (int i = 0; i < 4; i++) irq.push_back(i == 0);
    end
    if (s == SHIFT_IR) begin
      void'(irq.pop_front());
      irq.push_back(d);
    end
    if (s == UPDATE_IR) begin
      m_ir = 0;
      foreach (irq[i]) m_ir |= int'(irq[i]) << i;
    end
    if (s == CAP_DR) begin
      drq = {};
      if (m_ir == 1) for (int i = 0; i < 32; i++) drq.push_back(IDV[i]);
      else if (!is_bsr(m_ir)) drq.push_back(1'b0);
    end
    if (s == SHIFT_DR && drq.size() > 0) begin
      void'(drq.pop_front());
      drq.push_back(d);
    end
    m_st = nxt[int'(s)][int'(t)];
    if (m_st == TLR) m_ir = 1;
  endtask
  task automatic check_all();
    logic e_tdo;
    e_tdo = m_st == SHIFT_IR ? irq[0] :
            m_st != SHIFT_DR ? 1'b0 :
            is_bsr(m_ir) ? bsr_so : (drq.size() > 0 ? drq[0] : 1'b0);
    chk("state", tap_state, 32'(m_st));
    chk("tdo", tdo, e_tdo);
    chk("tdo_en", tdo_en, m_st == SHIFT_IR || m_st == SHIFT_DR);
    chk("bsr_si", bsr_si, tdi);
    chk("clock_dr_en", clock_dr_en, is_bsr(m_ir) && (m_st == CAP_DR || m_st == SHIFT_DR));
    chk("shift_dr", shift_dr, m_st == SHIFT_DR);
    chk("update_dr", update_dr, is_bsr(m_ir) && m_st == UPDATE_DR);
    chk("sample", sample, m_ir == 0 || m_ir == 2);
    chk("preload", preload, m_ir == 0 || m_ir == 3);
    chk("mode", mode, m_ir == 0);
  endtask
  task automatic step(input logic r, input logic t, input logic d);
    @(negedge tck);
    rst = r;
    tms = t;
    tdi = d;
    bsr_so = 1'($urandom_range(0, 1));
    @(posedge tck);
    model_edge(r, t, d);
    #1;
    check_all();
  endtask
  task automatic load_ir(input logic [3:0] v, output logic [3:0] cap);
    step(0, 1, 0);
    step(0, 1, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    cap[0] = tdo;
    for (int i = 0; i < 4; i++) begin
      step(0, i == 3, v[i]);
      if (i < 3) cap[i+1] = tdo;
    end
    step(0, 1, 0);
    step(0, 0, 0);
  endtask
  initial begin
    logic [3:0] cap, by, pat;
    logic [31:0] id;
    int n_cde, n_sd, n_ud, n_mode;
    logic [7:0] walk;
    arc(TLR, RTI, TLR);             arc(RTI, RTI, SEL_DR);
    arc(SEL_DR, CAP_DR, SEL_IR);    arc(SEL_IR, CAP_IR, TLR);
    arc(CAP_DR, SHIFT_DR, EXIT1_DR); arc(SHIFT_DR, SHIFT_DR, EXIT1_DR);
    arc(EXIT1_DR, PAUSE_DR, UPDATE_DR); arc(PAUSE_DR, PAUSE_DR, EXIT2_DR);
    arc(EXIT2_DR, SHIFT_DR, UPDATE_DR); arc(UPDATE_DR, RTI, SEL_DR);
    arc(CAP_IR, SHIFT_IR, EXIT1_IR); arc(SHIFT_IR, SHIFT_IR, EXIT1_IR);
    arc(EXIT1_IR, PAUSE_IR, UPDATE_IR); arc(PAUSE_IR, PAUSE_IR, EXIT2_IR);
    arc(EXIT2_IR, SHIFT_IR, UPDATE_IR); arc(UPDATE_IR, RTI, SEL_DR);
    tbl[0]  = '{1, 1, 0, TLR,       0, 0, 0};
    tbl[1]  = '{0, 0, 0, RTI,       0, 0, 0};
    tbl[2]  = '{0, 1, 0, SEL_DR,    0, 0, 0};
    tbl[3]  = '{0, 1, 0, SEL_IR,    0, 0, 0};
    tbl[4]  = '{0, 0, 0, CAP_IR,    0, 0, 0};
    tbl[5]  = '{0, 0, 0, SHIFT_IR,  1, 1, 0};
    tbl[6]  = '{0, 0, 0, SHIFT_IR,  0, 1, 0};
    tbl[7]  = '{0, 0, 0, SHIFT_IR,  0, 1, 0};
    tbl[8]  = '{0, 0, 0, SHIFT_IR,  0, 1, 0};
    tbl[9]  = '{0, 1, 0, EXIT1_IR,  0, 0, 0};
    tbl[10] = '{0, 1, 0, UPDATE_IR, 0, 0, 0};
    tbl[11] = '{0, 0, 0, RTI,       0, 0, 1};
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].r, tbl[i].t, tbl[i].d);
      chk("tbl_state", tap_state, 32'(tbl[i].st));
      chk("tbl_tdo", tdo, tbl[i].tdo);
      chk("tbl_tdo_en", tdo_en, tbl[i].en);
      chk("tbl_mode", mode, tbl[i].mode);
    end
    step(0, 1, 0);
    step(0, 0, 0);
    step(0, 0, 1);
    step(0, 0, 0);
    step(1, 0, 1);
    chk("rst_state", tap_state, 32'(TLR));
    chk("rst_tdo_en", tdo_en, 0);
    chk("rst_mode", mode, 0);
    chk("rst_sample", sample, 0);
    step(0, 0, 0);
    step(0, 1, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    id[0] = tdo;
    for (int i = 1; i < 32; i++) begin
      step(0, 0, 1'($urandom_range(0, 1)));
      id[i] = tdo;
    end
    chk("idcode_first", id[0], 1);
    chk("idcode_read", id, IDV);
    step(0, 1, 0);
    step(0, 1, 0);
    step(0, 0, 0);
    load_ir(4'h0, cap);
    chk("ir_capture", cap, 4'b0001);
    chk("extest_mode", mode, 1);
    chk("extest_sample", sample, 1);
    chk("extest_preload", preload, 1);
    load_ir(4'h7, cap);
    chk("unknown_mode", mode, 0);
    step(0, 1, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    by[0] = tdo;
    pat = 4'b1101;
    for (int i = 0; i < 4; i++) begin
      step(0, i == 3, pat[i]);
      if (i < 3) by[i+1] = tdo;
    end
    chk("bypass_seq", by, 4'b1010);
    step(0, 1, 0);
    step(0, 0, 0);
    load_ir(4'h3, cap);
    n_cde = 0; n_sd = 0; n_ud = 0; n_mode = 0;
    walk = 8'b0110_0001;
    for (int i = 0; i < 8; i++) begin
      step(0, walk[i], 0);
      n_cde += int'(clock_dr_en);
      n_sd += int'(shift_dr);
      n_ud += int'(update_dr);
      n_mode += int'(mode);
    end
    chk("bsr_clock_dr_cycles", n_cde, 4);
    chk("bsr_shift_dr_cycles", n_sd, 3);
    chk("bsr_update_dr_cycles", n_ud, 1);
    chk("bsr_mode_cycles", n_mode, 0);
    load_ir(4'h0, cap);
    step(0, 1, 0);
    step(0, 1, 0);
    step(0, 0, 0);
    step(0, 1, 0);
    step(0, 0, 0);
    chk("pause_ir", tap_state, 32'(PAUSE_IR));
    for (int i = 0; i < 5; i++) step(0, 1, 0);
    chk("tms_reset_state", tap_state, 32'(TLR));
    chk("tms_reset_mode", mode, 0);
    step(0, 0, 0);
    load_ir(4'h0, cap);
    for (int i = 0; i < 3; i++) step(0, 1, 0);
    chk("tlr_forces_idcode", mode, 0);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 63) == 0, $urandom_range(0, 99) < 35, 1'($urandom_range(0, 1)));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
